// File: rtl/cache_pkg.sv
// Shared types and default block geometry for the cache miss/fill path.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    localparam int unsigned DEF_WORDS_PER_BLOCK = 8;
    localparam int unsigned BLOCK_BYTES         = 2 * DEF_WORDS_PER_BLOCK;
    localparam int unsigned OFFSET_BITS         = $clog2(BLOCK_BYTES);

    // Words are 2 bytes wide.
    function automatic int unsigned block_bytes(input int unsigned words);
        return 2 * words;
    endfunction

endpackage

// File: rtl/cache_fill_counter.sv
// Synchronous up-counter with clear and enable; clear has priority.
module fill_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss controller: stalls the pipeline, fetches a whole block word by word from main
// memory, streams each word into the data array and writes the tag with the last word.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned DATA_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_address,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] cache_word_address,
    output logic [DATA_W-1:0] cache_data
);

    localparam int unsigned       CNT_W       = $clog2(WORDS_PER_BLOCK) + 1;
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(block_bytes(WORDS_PER_BLOCK) - 1);
    localparam logic [CNT_W-1:0]  ALL_WORDS   = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]  LAST_WORD   = CNT_W'(WORDS_PER_BLOCK - 1);

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  req_cnt, rcv_cnt;
    logic [ADDR_W-1:0] req_off, rcv_off;
    logic              start;

    assign start      = (state_q == IDLE) && miss_detected;
    assign req_off    = ADDR_W'(req_cnt) << 1;
    assign rcv_off    = ADDR_W'(rcv_cnt) << 1;
    assign cache_data = mem_data;

    // Both counters restart on reset and at the start of every fill.
    fill_counter #(
        .WIDTH (CNT_W)
    ) u_req_cnt (
        .clk   (clk),
        .clr   (rst | start),
        .en    (mem_en),
        .count (req_cnt)
    );

    fill_counter #(
        .WIDTH (CNT_W)
    ) u_rcv_cnt (
        .clk   (clk),
        .clr   (rst | start),
        .en    (write_data_array),
        .count (rcv_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        base_d             = base_q;
        fsm_busy           = 1'b0;
        mem_en             = 1'b0;
        mem_address        = base_q;
        write_data_array   = 1'b0;
        write_tag_array    = 1'b0;
        cache_word_address = base_q;

        unique case (state_q)
            IDLE: begin
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    base_d  = miss_address & ~OFFSET_MASK;
                    state_d = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (req_cnt < ALL_WORDS) begin
                    mem_en      = 1'b1;
                    mem_address = base_q + req_off;
                end
                // Only returned words are counted, so latency and gaps do not matter.
                if (mem_data_valid) begin
                    write_data_array   = 1'b1;
                    cache_word_address = base_q + rcv_off;
                    if (rcv_cnt == LAST_WORD) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
        endcase
    end

endmodule
